pipe_barrel_rotator: RTL and testbench
======================================

PIPE_BARREL_ROTATOR -- requirements
Module: pipe_barrel_rotator

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width; power of two, 8..128.
REQ-002 SHALL have parameter STAGES, default 3, number of register stages; 1..log2(WIDTH).
REQ-003 SHALL derive SW = log2(WIDTH) internally as the shift-amount width.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  input word present.
REQ-007 SHALL have port in_ready  output  1  block accepts the input word this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  word to rotate or shift.
REQ-009 SHALL have port in_shamt  input  SW  shift amount, 0..WIDTH-1.
REQ-010 SHALL have port in_mode  input  2  operation: 00 rotate left, 01 rotate right, 10 logical shift left, 11 logical shift right.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_data  output  WIDTH  result word.
REQ-014 SHALL have port occupancy  output  SW  count of valid words held in the pipeline (0..STAGES).

Function
REQ-015 SHALL split the SW binary mux levels (level i moves by 2^i) over STAGES register stages; stage s implements levels floor(s*SW/STAGES) to floor((s+1)*SW/STAGES)-1.
REQ-016 SHALL carry data, remaining shamt bits, mode and a valid bit through every stage register.
REQ-017 SHALL compute rotate left as (d << n) | (d >> (WIDTH-n)) mod WIDTH, and rotate right as (d >> n) | (d << (WIDTH-n)).
REQ-018 SHALL zero-fill vacated bits in logical shift modes.
REQ-019 SHALL return out_data == in_data for shamt 0 in all four modes.
REQ-020 SHALL define advance = !out_valid || out_ready; all stages shift forward on advance, all hold otherwise.
REQ-021 SHALL drive in_ready = advance (combinational from out_valid, out_ready).
REQ-022 SHALL accept a word on in_valid && in_ready; latency from acceptance to out_valid is exactly STAGES cycles with no stall.
REQ-023 SHALL sustain one word per cycle when out_ready stays high.
REQ-024 SHALL let bubbles (in_valid low on advance) propagate as invalid slots; bubbles are not compressed.
REQ-025 SHALL hold out_data, out_valid and all stage contents stable while out_valid && !out_ready.
REQ-026 SHALL keep occupancy equal to the number of set stage valid bits, updated in the same cycle as the stages.
REQ-027 SHALL ignore in_data, in_shamt and in_mode when the word is not accepted.
REQ-028 SHALL preserve word order; no word is dropped or duplicated.

Reset
REQ-029 SHALL on rst_n low clear every stage valid bit, out_valid and occupancy to 0, and out_data to 0, asynchronously.
REQ-030 SHALL discard all in-flight words on reset mid-operation; none appear after release.
REQ-031 SHALL drive in_ready high in the first cycle after release (out_valid = 0).
REQ-032 SHALL leave stage data registers need not be reset beyond out_data; valid bits gate all visibility.

Verification (WIDTH=64, STAGES=3)
REQ-033 SHALL cover: in_data=0x0123456789ABCDEF, shamt=4, mode 00, out_ready=1 -> out_data=0x123456789ABCDEF0 exactly 3 cycles after acceptance.
REQ-034 SHALL cover: same data, shamt=4, modes 01/10/11 -> 0xF0123456789ABCDE / 0x123456789ABCDEF0 / 0x00123456789ABCDE.
REQ-035 SHALL cover: shamt 0 and 63 with data 0x8000000000000001, all modes -> 0x8000000000000001 (shamt 0); 0xC000000000000000, 0x0000000000000003, 0x8000000000000000, 0x0000000000000001 (shamt 63, modes 00..11).
REQ-036 SHALL cover: 10 back-to-back words, out_ready low for 4 cycles mid-stream -> in_ready low during stall, occupancy=3, output stable, all 10 results in order, none lost.
REQ-037 SHALL cover: rst_n asserted with occupancy=3 -> out_valid=0, occupancy=0 immediately; no stale output after release.
REQ-038 SHALL cover: random data/shamt/mode against a reference model with random in_valid/out_ready, STAGES in {1,3,6} -> zero mismatches.

Source files
------------

// File: rtl/pipe_barrel_rotator.sv
// rtl/pipe_barrel_rotator.sv - pipelined barrel rotator/shifter with valid/ready flow control
module pipe_barrel_rotator #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 3,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SW-1:0]     in_shamt,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [SW-1:0]     occupancy
);

    // Link arrays: index s is the input of stage s, index STAGES is the pipeline output.
    logic [WIDTH-1:0] l_d  [STAGES+1];
    logic             l_v  [STAGES+1];
    logic [SW-1:0]    l_sh [STAGES];
    logic [1:0]       l_md [STAGES];
    logic             advance;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    assign l_d[0]    = in_data;
    assign l_v[0]    = in_valid;
    assign l_sh[0]   = in_shamt;
    assign l_md[0]   = in_mode;

    assign out_valid = l_v[STAGES];
    assign out_data  = l_d[STAGES];

    // One mux level: every mode composes across levels, so each level just moves by amt.
    function automatic logic [WIDTH-1:0] move_level(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       md,
                                                    input int               amt);
        case (md)
            2'b00:   move_level = (d << amt) | (d >> (WIDTH - amt));
            2'b01:   move_level = (d >> amt) | (d << (WIDTH - amt));
            2'b10:   move_level = d << amt;
            default: move_level = d >> amt;
        endcase
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = (s * SW) / STAGES;
        localparam int HI = ((s + 1) * SW) / STAGES;

        logic [WIDTH-1:0] mux_d;
        logic [WIDTH-1:0] d_q;
        logic             v_q;

        always_comb begin
            mux_d = l_d[s];
            for (int i = LO; i < HI; i++) begin
                if ((l_sh[s] & (SW'(1) << i)) != '0) begin
                    mux_d = move_level(mux_d, l_md[s], 1 << i);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q <= '0;
                v_q <= 1'b0;
            end else if (advance) begin
                d_q <= mux_d;
                v_q <= l_v[s];
            end
        end

        assign l_d[s+1] = d_q;
        assign l_v[s+1] = v_q;

        // The last stage consumes all remaining shift bits, so only earlier stages carry control.
        if (s < STAGES - 1) begin : g_carry
            logic [SW-1:0] sh_q;
            logic [1:0]    md_q;

            always_ff @(posedge clk) begin
                if (advance) begin
                    sh_q <= l_sh[s];
                    md_q <= l_md[s];
                end
            end

            assign l_sh[s+1] = sh_q;
            assign l_md[s+1] = md_q;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int s = 1; s <= STAGES; s++) begin
            occupancy = occupancy + SW'(l_v[s]);
        end
    end

endmodule

// File: tb/tb_pipe_barrel_rotator.sv
// tb/tb_pipe_barrel_rotator.sv - random and directed checks of pipe_barrel_rotator against a reference model
module tb_pipe_barrel_rotator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [5:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        out_ready;

    logic        in_ready_v  [3];
    logic        out_valid_v [3];
    logic [63:0] out_data_v  [3];
    logic [5:0]  occ_v       [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_barrel_rotator #(.WIDTH(64), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]),
        .occupancy(occ_v[0]));

    pipe_barrel_rotator #(.WIDTH(64), .STAGES(3)) u_dut_s3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]),
        .occupancy(occ_v[1]));

    pipe_barrel_rotator #(.WIDTH(64), .STAGES(6)) u_dut_s6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_data(out_data_v[2]),
        .occupancy(occ_v[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Rotations taken from a doubled word; logical shifts are plain shifts.
    function automatic logic [63:0] ref_op(input logic [63:0] d, input int n, input logic [1:0] m);
        logic [127:0] dd;
        logic [127:0] t;
        dd = {d, d};
        case (m)
            2'b00: begin t = dd << n; return t[127:64]; end
            2'b01: begin t = dd >> n; return t[63:0];  end
            2'b10: return d << n;
            default: return d >> n;
        endcase
    endfunction

    function automatic logic [63:0] word_d(input int i);
        return 64'h0123456789ABCDEF ^ (64'(i) * 64'h0000_0000_0001_1111);
    endfunction

    // Per-instance scoreboard: expected results queued on acceptance, popped on output handshake.
    for (genvar k = 0; k < 3; k++) begin : g_mon
        logic [63:0] q[$];
        int          pops = 0;
        logic [63:0] exp_w;

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
            end else begin
                check($sformatf("occupancy_s%0d", k), 64'(occ_v[k]), 64'(q.size()));
                if (out_valid_v[k] && out_ready) begin
                    exp_w = (q.size() > 0) ? q.pop_front() : ~out_data_v[k];
                    check($sformatf("sb_data_s%0d", k), out_data_v[k], exp_w);
                    pops++;
                end
                if (in_valid && in_ready_v[k]) begin
                    q.push_back(ref_op(in_data, int'(in_shamt), in_mode));
                end
            end
        end
    end

    // Caller is #1 after a rising edge; measures acceptance-to-out_valid latency of the 3-stage DUT.
    task automatic send_one(input string tag, input logic [63:0] d, input int sh,
                            input logic [1:0] md, input logic [63:0] exp);
        int lat;
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = 6'(sh);
        in_mode   = md;
        out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                in_shamt = 6'($urandom);
                in_mode  = 2'($urandom);
            end
        end while (!out_valid_v[1] && lat < 12);
        check({tag, "_lat"}, 64'(lat), 64'd3);
        check({tag, "_data"}, out_data_v[1], exp);
    endtask

    initial begin
        logic [63:0] d35;
        logic [63:0] exp_hold;
        int          idx;
        int          base;
        logic        acc;
        logic        stale;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid_v[1]), 64'd0);
        check("rst_occupancy", 64'(occ_v[1]), 64'd0);
        check("rst_out_data", out_data_v[1], 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready_v[1]), 64'd1);
        @(posedge clk); #1;

        send_one("rotl4", 64'h0123456789ABCDEF, 4, 2'b00, 64'h123456789ABCDEF0);
        send_one("rotr4", 64'h0123456789ABCDEF, 4, 2'b01, 64'hF0123456789ABCDE);
        send_one("shl4",  64'h0123456789ABCDEF, 4, 2'b10, 64'h123456789ABCDEF0);
        send_one("shr4",  64'h0123456789ABCDEF, 4, 2'b11, 64'h00123456789ABCDE);
        d35 = 64'h8000000000000001;
        for (int m = 0; m < 4; m++) begin
            send_one($sformatf("sh0_m%0d", m), d35, 0, 2'(m), d35);
        end
        send_one("sh63_m0", d35, 63, 2'b00, 64'hC000000000000000);
        send_one("sh63_m1", d35, 63, 2'b01, 64'h0000000000000003);
        send_one("sh63_m2", d35, 63, 2'b10, 64'h8000000000000000);
        send_one("sh63_m3", d35, 63, 2'b11, 64'h0000000000000001);

        // Ten back-to-back words with a four-cycle downstream stall.
        repeat (6) @(posedge clk);
        #1;
        idx  = 0;
        base = g_mon[1].pops;
        exp_hold = ref_op(word_d(3), (3 * 7) % 64, 2'(3));
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 9);
            if (idx < 10) begin
                in_valid = 1'b1;
                in_data  = word_d(idx);
                in_shamt = 6'((idx * 7) % 64);
                in_mode  = 2'(idx);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 6 && cyc <= 9) begin
                check($sformatf("stall_in_ready_c%0d", cyc), 64'(in_ready_v[1]), 64'd0);
                check($sformatf("stall_occ_c%0d", cyc), 64'(occ_v[1]), 64'd3);
                check($sformatf("stall_valid_c%0d", cyc), 64'(out_valid_v[1]), 64'd1);
                check($sformatf("stall_data_c%0d", cyc), out_data_v[1], exp_hold);
            end
            acc = in_valid && in_ready_v[1];
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("stall_accepted", 64'(idx), 64'd10);
        check("stall_delivered", 64'(g_mon[1].pops - base), 64'd10);

        // Reset with a full pipeline.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data  = {$urandom, $urandom};
            in_shamt = 6'($urandom);
            in_mode  = 2'($urandom);
            @(posedge clk); #1;
        end
        check("full_occ", 64'(occ_v[1]), 64'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid_v[1]), 64'd0);
        check("midrst_occ", 64'(occ_v[1]), 64'd0);
        check("midrst_out_data", out_data_v[1], 64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid_v[0] || out_valid_v[1] || out_valid_v[2]) stale = 1'b1;
        end
        check("no_stale_output", 64'(stale), 64'd0);

        // Random traffic and backpressure on all three pipeline depths.
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = {$urandom, $urandom};
            in_shamt  = 6'($urandom);
            in_mode   = 2'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drain_valid_%0d", k), 64'(out_valid_v[k]), 64'd0);
            check($sformatf("drain_occ_%0d", k), 64'(occ_v[k]), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
